// File: rtl/ser_arb_pkg.sv
// Shared types and constants for the serial transmit arbiter.
// Frame format is 8N1: one start bit, eight data bits, one stop bit.
package ser_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } ser_state_e;

    localparam int FRAME_BITS = 10;

    function automatic int baud_w(input int clkdiv);
        return (clkdiv > 2) ? $clog2(clkdiv) : 1;
    endfunction

endpackage

// File: rtl/ser_tx_shifter.sv
// 8N1 serialiser: baud/bit counters, shift register, ser_tx and busy.
// load is taken only while done (FSM idle) is high.
module ser_tx_shifter
    import ser_arb_pkg::*;
#(
    parameter int CLKDIV = 20
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       load,
    input  logic [7:0] load_data,
    output logic       done,
    output logic       ser_tx,
    output logic       busy
);

    localparam int BW = baud_w(CLKDIV);
    localparam int DATA_BITS = FRAME_BITS - 2;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKDIV - 1);
    localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

    ser_state_e    state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [7:0]    shreg, shreg_n;
    logic          tx_n, busy_n;
    logic          baud_end;

    assign baud_end = (baud == BAUD_LAST);
    assign done = (state == IDLE);

    always_comb begin
        state_n = state;
        baud_n  = baud_end ? '0 : baud + 1'b1;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        tx_n    = ser_tx;
        busy_n  = busy;
        unique case (state)
            IDLE: begin
                baud_n = '0;
                if (load) begin
                    state_n = START;
                    shreg_n = load_data;
                    tx_n    = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            START: begin
                if (baud_end) begin
                    state_n = DATA;
                    tx_n    = shreg[0];
                end
            end
            DATA: begin
                if (baud_end) begin
                    if (bit_cnt == BIT_LAST) begin
                        state_n = STOP;
                        bit_n   = '0;
                        tx_n    = 1'b1;
                    end else begin
                        bit_n   = bit_cnt + 1'b1;
                        shreg_n = shreg >> 1;
                        tx_n    = shreg[1];
                    end
                end
            end
            STOP: begin
                if (baud_end) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Reset drops any frame in flight and forces the line idle-high.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            ser_tx  <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_cnt <= bit_n;
            shreg   <= shreg_n;
            ser_tx  <= tx_n;
            busy    <= busy_n;
        end
    end

endmodule

// File: rtl/ser_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 ser_tx line among N_REQ requesters.
// Define UART_ARB_LOCK_EN to keep a grant until the requester's req_last byte.
module ser_tx_arbiter
    import ser_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int CLKDIV = 20,
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic               ser_tx,
    output logic               busy,
    output logic [GW-1:0]      grant_id
);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
        $error("ser_tx_arbiter: N_REQ must be 2..8");
    end
    if (CLKDIV < 2) begin : g_bad_clkdiv
        $error("ser_tx_arbiter: CLKDIV must be >= 2");
    end

    logic             sh_done;
    logic             fire;
    logic             found;
    logic [GW-1:0]    win;
    logic [GW-1:0]    idx;
    logic [GW-1:0]    rr_ptr;
    logic [N_REQ-1:0] cand;

`ifdef UART_ARB_LOCK_EN
    logic          locked;
    logic [GW-1:0] lock_id;

    always_comb begin
        cand = req_valid;
        if (locked) begin
            cand = req_valid & (N_REQ'(1) << lock_id);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            locked  <= 1'b0;
            lock_id <= '0;
        end else if (fire) begin
            locked  <= ~req_last[win];
            lock_id <= win;
        end
    end
`else
    logic unused_last;
    assign unused_last = ^req_last;
    assign cand = req_valid;
`endif

    // rr_ptr holds the highest-priority index for the next grant.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = GW'((int'(rr_ptr) + k) % N_REQ);
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (resetn && sh_done && found) begin
            req_ready = N_REQ'(1) << win;
        end
    end

    assign fire = |(req_ready & req_valid);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr   <= '0;
            grant_id <= '0;
        end else if (fire) begin
            grant_id <= win;
            rr_ptr   <= (win == GW'(N_REQ - 1)) ? '0 : win + 1'b1;
        end
    end

    ser_tx_shifter #(
        .CLKDIV(CLKDIV)
    ) u_shifter (
        .clk      (clk),
        .resetn   (resetn),
        .load     (fire),
        .load_data(req_data[8*win +: 8]),
        .done     (sh_done),
        .ser_tx   (ser_tx),
        .busy     (busy)
    );

endmodule

// File: tb/tb_ser_tx_arbiter.sv
// Bench for ser_tx_arbiter: frame-level model, line decoder, directed cases.
// Build with UART_ARB_LOCK_EN defined to exercise packet locking.
module tb_ser_tx_arbiter;

    localparam int N = 2;
    localparam int CLKDIV = 20;
    localparam int FRAME = 10 * CLKDIV;

    logic           clk;
    logic           resetn;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           ser_tx;
    logic           busy;
    logic [0:0]     grant_id;

    ser_tx_arbiter #(
        .N_REQ (N),
        .CLKDIV(CLKDIV)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_last (req_last),
        .req_ready(req_ready),
        .ser_tx   (ser_tx),
        .busy     (busy),
        .grant_id (grant_id)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Requester drivers: queued bytes held until accepted, plus raw pulses.
    logic [8:0]   fq [N][$];
    logic [N-1:0] fv = '0;
    logic [N-1:0] fl = '0;
    logic [7:0]   fd [N];
    logic [N-1:0] pv = '0;
    logic [7:0]   pd [N];
    logic [N-1:0] acc = '0;

    initial begin
        for (int i = 0; i < N; i++) begin
            fd[i] = '0;
            pd[i] = '0;
        end
    end

    always_comb begin
        req_data  = '0;
        req_valid = fv | pv;
        req_last  = fl;
        for (int i = 0; i < N; i++) begin
            req_data[8*i +: 8] = pv[i] ? pd[i] : fd[i];
        end
    end

    always @(posedge clk) begin
        #2;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && fq[i].size() > 0) void'(fq[i].pop_front());
            if (fq[i].size() > 0) begin
                fv[i] = 1'b1;
                fd[i] = fq[i][0][7:0];
                fl[i] = fq[i][0][8];
            end else begin
                fv[i] = 1'b0;
                fl[i] = 1'b0;
            end
        end
    end

    // Model: frame timeline as elapsed cycles since the accepting edge.
    int         t = -1;
    int         rr = 0;
    int         gexp = 0;
    bit         lk = 1'b0;
    int         lk_id = 0;
    int         w;
    logic [9:0] fr = 10'h3ff;

    function automatic int pick(input logic [N-1:0] v);
        int r;
        int id;
        r = -1;
        for (int k = 0; k < N; k++) begin
            id = (rr + k) % N;
`ifdef UART_ARB_LOCK_EN
            if (lk && id != lk_id) continue;
`endif
            if (r < 0 && v[id]) r = id;
        end
        return r;
    endfunction

    function automatic int exp_ready();
        int p;
        p = pick(req_valid);
        if (!resetn || t >= 0 || p < 0) return 0;
        return 1 << p;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            t = -1; rr = 0; gexp = 0; lk = 1'b0; lk_id = 0;
        end else if (t >= 0) begin
            t++;
            if (t == FRAME) t = -1;
        end else begin
            w = pick(req_valid);
            if (w >= 0) begin
                fr = {1'b1, req_data[8*w +: 8], 1'b0};
                t = 0;
                gexp = w;
                rr = (w + 1) % N;
                lk = !req_last[w];
                lk_id = w;
            end
        end
    end

    always @(negedge clk) begin
        chk("ready", int'(req_ready), exp_ready());
        chk("ser_tx", int'(ser_tx), (t >= 0) ? int'(fr[t / CLKDIV]) : 1);
        chk("busy", int'(busy), (t >= 0) ? 1 : 0);
        chk("grant_id", int'(grant_id), gexp);
    end

    // Line decoder samples mid-bit; records grant_id at each start bit.
    logic [7:0] dq[$];
    int         gq[$];
    int         dcnt = -1;
    int         kb;
    logic [7:0] dsh = '0;
    int         busy_cyc = 0;

    always @(negedge clk) begin
        acc = req_valid & req_ready;
        if (busy) busy_cyc++;
        if (!resetn) begin
            dcnt = -1;
        end else if (dcnt < 0) begin
            if (!ser_tx) begin
                dcnt = 0;
                gq.push_back(int'(grant_id));
            end
        end else begin
            dcnt++;
            if (dcnt % CLKDIV == CLKDIV / 2) begin
                kb = dcnt / CLKDIV;
                if (kb >= 1 && kb <= 8) dsh[kb-1] = ser_tx;
                if (kb == 9) begin
                    if (ser_tx) dq.push_back(dsh);
                    dcnt = -1;
                end
            end
        end
    end

    function automatic int dqa(input int i);
        return (i < dq.size()) ? int'(dq[i]) : -1;
    endfunction

    function automatic int gqa(input int i);
        return (i < gq.size()) ? gq[i] : -1;
    endfunction

    task automatic wait_busy(input string nm);
        int n = 0;
        while (!busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(nm, int'(busy), 1);
    endtask

    task automatic clr();
        dq.delete();
        gq.delete();
    endtask

    initial begin
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #2 resetn = 1'b1;

        busy_cyc = 0;
        repeat (500) @(posedge clk);
        chk("idle_busy_cycles", busy_cyc, 0);
        chk("idle_bytes", dq.size(), 0);

        @(posedge clk) #1;
        clr();
        fq[0].push_back({1'b1, 8'h41});
        fq[0].push_back({1'b1, 8'h41});
        fq[1].push_back({1'b1, 8'h42});
        fq[1].push_back({1'b1, 8'h42});
        repeat (4 * (FRAME + 1) + 40) @(posedge clk);
        chk("cont_n", dq.size(), 4);
        chk("cont_b0", dqa(0), 'h41);
        chk("cont_b1", dqa(1), 'h42);
        chk("cont_b2", dqa(2), 'h41);
        chk("cont_b3", dqa(3), 'h42);
        chk("cont_g0", gqa(0), 0);
        chk("cont_g1", gqa(1), 1);
        chk("cont_g2", gqa(2), 0);
        chk("cont_g3", gqa(3), 1);

        @(posedge clk) #1;
        clr();
        busy_cyc = 0;
        fq[0].push_back({1'b1, 8'h55});
        @(negedge clk);
        chk("single_ready", int'(req_ready), 1);
        @(negedge clk);
        chk("single_start", int'(ser_tx), 0);
        repeat (230) @(posedge clk);
        chk("single_busy_cycles", busy_cyc, 200);
        chk("single_byte", dqa(0), 'h55);

        @(posedge clk) #1;
        clr();
        fq[0].push_back({1'b1, 8'h0f});
        wait_busy("rst_start");
        repeat (90) @(negedge clk);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("rst_tx_async", int'(ser_tx), 1);
        chk("rst_busy_async", int'(busy), 0);
        chk("rst_grant", int'(grant_id), 0);
        repeat (3) @(posedge clk);
        #2 resetn = 1'b1;
        @(posedge clk) #1;
        clr();
        fq[1].push_back({1'b1, 8'h7e});
        repeat (230) @(posedge clk);
        chk("rst_after_n", dq.size(), 1);
        chk("rst_after_byte", dqa(0), 'h7e);
        @(posedge clk) #1;
        clr();
        fq[0].push_back({1'b1, 8'h10});
        fq[1].push_back({1'b1, 8'h20});
        repeat (2 * (FRAME + 1) + 40) @(posedge clk);
        chk("rst_cont_g0", gqa(0), 0);
        chk("rst_cont_b0", dqa(0), 'h10);
        chk("rst_cont_b1", dqa(1), 'h20);

        @(posedge clk) #1;
        clr();
        fq[0].push_back({1'b0, 8'h31});
        fq[0].push_back({1'b1, 8'h32});
        fq[1].push_back({1'b1, 8'h39});
        repeat (3 * (FRAME + 1) + 40) @(posedge clk);
        chk("lock_n", dq.size(), 3);
        chk("lock_b0", dqa(0), 'h31);
`ifdef UART_ARB_LOCK_EN
        chk("lock_b1", dqa(1), 'h32);
        chk("lock_b2", dqa(2), 'h39);
`else
        chk("lock_b1", dqa(1), 'h39);
        chk("lock_b2", dqa(2), 'h32);
`endif

        @(posedge clk) #1;
        clr();
        fq[0].push_back({1'b1, 8'h00});
        wait_busy("drop_start");
        repeat (185) @(negedge clk);
        @(posedge clk);
        #2;
        pd[1] = 8'haa;
        pv = 2'b10;
        @(posedge clk);
        #2 pv = 2'b00;
        @(negedge clk);
        chk("drop_tx_high", int'(ser_tx), 1);
        repeat (40) @(posedge clk);
        chk("drop_n", dq.size(), 1);
        chk("drop_byte", dqa(0), 'h00);
        chk("drop_grant", int'(grant_id), 0);
        @(posedge clk) #1;
        clr();
        fq[0].push_back({1'b1, 8'h01});
        fq[1].push_back({1'b1, 8'h02});
        repeat (2 * (FRAME + 1) + 40) @(posedge clk);
        chk("drop_next_g0", gqa(0), 1);
        chk("drop_next_b0", dqa(0), 'h02);
        chk("drop_next_b1", dqa(1), 'h01);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
